// File: rtl/soc_reset_sequencer_pkg.sv
// soc_reset_pkg: shared types and constants for the SoC reset/PLL sequencer.
//   RstState      - sequencer state, encoding also drives the debug LEDs
//   LOCK_LOST_MAX - saturation value of the lock-loss event counter
package soc_reset_pkg;

   typedef enum logic [2:0] {
      RESET_HOLD = 3'd0,
      WAIT_LOCK  = 3'd1,
      RELEASE    = 3'd2,
      RUN        = 3'd3
   } RstState;

   localparam logic [7:0] LOCK_LOST_MAX = 8'd255;

endpackage

// File: rtl/soc_reset_sequencer_if.sv
// soc_reset_sequencer_if: status/control bundle between the reset sequencer
// and the SoC top.
//   pll_locked      - PLL lock indicator (to sequencer)
//   sw_reset_req    - single-cycle software re-reset request (to sequencer)
//   pll_reset       - active-high PLL reset (from sequencer)
//   domain_rst_n    - active-low domain resets, bit 0 released first
//   ready           - high only while the sequencer is in RUN
//   lock_lost_count - saturating count of lock-loss events
//   state_o         - current sequencer state for debug LEDs
// modport master: the sequencer; modport slave: the SoC top / environment.
interface soc_reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3
);
   import soc_reset_pkg::*;

   logic                   pll_locked;
   logic                   sw_reset_req;
   logic                   pll_reset;
   logic [NUM_DOMAINS-1:0] domain_rst_n;
   logic                   ready;
   logic [7:0]             lock_lost_count;
   logic [2:0]             state_o;

   modport master (
      input  pll_locked, sw_reset_req,
      output pll_reset, domain_rst_n, ready, lock_lost_count, state_o
   );

   modport slave (
      output pll_locked, sw_reset_req,
      input  pll_reset, domain_rst_n, ready, lock_lost_count, state_o
   );

endinterface

// File: rtl/soc_reset_sequencer_lock_debounce.sv
// lock_debounce: counts consecutive cycles of pll_locked=1.
//   clk, reset    - clock and synchronous active-high reset
//   clear         - holds the stable count at zero (sequencer not waiting for lock)
//   pll_locked    - raw, possibly glitchy PLL lock indicator
//   stable_locked - high on the cycle pll_locked is high and the count is at
//                   its terminal value LOCK_STABLE_CYCLES-1
module lock_debounce #(
   parameter int LOCK_STABLE_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic pll_locked,
   output logic stable_locked
);

   localparam int W = ($clog2(LOCK_STABLE_CYCLES) > 0) ? $clog2(LOCK_STABLE_CYCLES) : 1;

   logic [W-1:0] stable_cnt;
   logic         terminal;

   assign terminal      = (stable_cnt == W'(LOCK_STABLE_CYCLES - 1));
   assign stable_locked = pll_locked && terminal;

   always_ff @(posedge clk) begin
      if (reset || clear || !pll_locked) begin
         stable_cnt <= '0;
      end else if (!terminal) begin
         stable_cnt <= stable_cnt + W'(1);
      end
   end

endmodule

// File: rtl/soc_reset_sequencer.sv
// soc_reset_sequencer: power-on PLL reset, debounced lock wait, then staged
// release of NUM_DOMAINS active-low domain resets. Re-sequences on lock loss,
// lock timeout and software reset request.
//   clk   - raw board clock
//   reset - synchronous active-high system reset
//   bus   - soc_reset_sequencer_if.master (lock/request in, resets/status out)
// All outputs are registered.
module soc_reset_sequencer
   import soc_reset_pkg::*;
#(
   parameter int NUM_DOMAINS         = 3,
   parameter int POR_CYCLES          = 16,
   parameter int LOCK_STABLE_CYCLES  = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 1024,
   parameter int RELEASE_GAP_CYCLES  = 4,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   soc_reset_sequencer_if.master bus
);

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   RstState                state, state_d;
   logic [CNT_WIDTH-1:0]   cnt, cnt_d;
   logic [IDX_W-1:0]       idx, idx_d;

   logic                   pll_reset_q, pll_reset_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   ready_q, ready_d;
   logic [7:0]             lost_q, lost_d;

   logic stable_locked;
   logic active;        // RELEASE or RUN: domains may be out of reset
   logic lock_loss;
   logic sw_restart;
   logic release_step;  // gap elapsed with no overriding event

   lock_debounce #(
      .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
   ) u_lock_debounce (
      .clk          (clk),
      .reset        (reset),
      .clear        (state != WAIT_LOCK),
      .pll_locked   (bus.pll_locked),
      .stable_locked(stable_locked)
   );

   assign active       = (state == RELEASE) || (state == RUN);
   assign lock_loss    = active && !bus.pll_locked;
   assign sw_restart   = active && !lock_loss && bus.sw_reset_req;
   assign release_step = (state == RELEASE) && !lock_loss && !sw_restart &&
                         (cnt == CNT_WIDTH'(RELEASE_GAP_CYCLES - 1));

   // State register (also holds counter, index and the registered outputs)
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RESET_HOLD;
         cnt         <= '0;
         idx         <= '0;
         pll_reset_q <= 1'b1;
         dom_q       <= '0;
         ready_q     <= 1'b0;
         lost_q      <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         pll_reset_q <= pll_reset_d;
         dom_q       <= dom_d;
         ready_q     <= ready_d;
         lost_q      <= lost_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      cnt_d   = cnt + CNT_WIDTH'(1);
      idx_d   = idx;
      unique case (state)
         RESET_HOLD: begin
            if (cnt == CNT_WIDTH'(POR_CYCLES - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            // A lock completing on the timeout cycle still wins
            if (stable_locked) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt == CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1)) begin
               state_d = RESET_HOLD;
               cnt_d   = '0;
            end
         end
         RELEASE, RUN: begin
            if (state == RUN) cnt_d = cnt;
            if (lock_loss) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (sw_restart) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (release_step) begin
               cnt_d = '0;
               idx_d = idx + IDX_W'(1);
               if (idx == IDX_W'(NUM_DOMAINS - 1)) state_d = RUN;
            end
         end
         default: begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      pll_reset_d = (state_d == RESET_HOLD);
      ready_d     = (state_d == RUN);
      dom_d       = dom_q;
      lost_d      = lost_q;
      if (lock_loss || sw_restart || !active) begin
         dom_d = '0;
      end else if (release_step) begin
         // Releasing in index order keeps the vector of the form 0..01..1
         dom_d = dom_q | (NUM_DOMAINS'(1) << idx);
      end
      if (lock_loss && (lost_q != LOCK_LOST_MAX)) begin
         lost_d = lost_q + 8'd1;
      end
   end

   assign bus.pll_reset       = pll_reset_q;
   assign bus.domain_rst_n    = dom_q;
   assign bus.ready           = ready_q;
   assign bus.lock_lost_count = lost_q;
   assign bus.state_o         = state;

endmodule
